reg_dump_seq: RTL and testbench
===============================

// Module: reg_dump_seq
// PURPOSE
//  Post-run register dump sequencer for the pipelined DLX core; sits directly upstream of the core's instruction input.
//  During normal execution it passes control to instruction memory (override_inst=0).
//  After a cycle budget expires or halt_req is seen, it takes over the instruction port.
//  It injects one ADDI per architectural register and returns each register's busA readout on a valid/ready stream.
// PARAMETERS
//  RUN_CYCLES  121  cycles of normal execution after reset release before the dump starts (>=1)
//  NUM_REGS    32   registers dumped, indices 0..NUM_REGS-1 (<=32)
//  LATENCY     1    cycles from instruction injection until busA_probe reflects that instruction's rs field (>=1)
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous reset, active-low
//  halt_req       in   1   early dump request; sampled only in RUN
//  busA_probe     in   32  core register-file read port A
//  override_inst  out  1   1 = force_inst drives core instruction mux
//  force_inst     out  32  injected instruction
//  dump_valid     out  1   dump_idx/dump_data valid
//  dump_ready     in   1   consumer accepts the current word
//  dump_idx       out  5   register index of dump_data
//  dump_data      out  32  captured register value
//  busy           out  1   dump in progress (ISSUE/WAIT/VALID)
//  done           out  1   all registers dumped; sticky until reset
// BEHAVIOUR
//  Reset (reset=0, async)
//   - state=RUN, run_cnt=0, k=0, wait_cnt=0.
//   - All outputs are 0: override_inst, force_inst, dump_valid, dump_idx, dump_data, busy, done.
//   - Reset asserted mid-dump aborts immediately; override_inst drops in the same cycle and no partial word is emitted.
//  RUN
//   - override_inst=0; run_cnt increments every cycle.
//   - Go to ISSUE when run_cnt==RUN_CYCLES-1 OR halt_req==1.
//   - If both happen in the same cycle, the result is a single transition, identical to either alone.
//  ISSUE (1 cycle)
//   - override_inst=1; force_inst={6'b001000,k[4:0],5'b0,16'b0}, i.e. ADDI r0,rk,0: reads rk and writes r0, so it has no side effects.
//   - wait_cnt=0; next state is WAIT.
//  WAIT (LATENCY cycles)
//   - force_inst is held; wait_cnt increments each cycle.
//   - At the clock edge ending the cycle where wait_cnt==LATENCY-1: dump_data<=busA_probe, dump_idx<=k, next state is VALID.
//  VALID
//   - dump_valid=1; force_inst and dump_data are held stable while dump_ready=0 (unbounded stall allowed).
//   - On the edge where dump_valid&&dump_ready: if k==NUM_REGS-1 go to DONE, else k<=k+1 and go to ISSUE.
//   - dump_valid is deasserted on the next cycle; there is never back-to-back valid.
//  DONE
//   - done=1, busy=0, override_inst=1, force_inst=32'h0000_0000 (NOP), dump_valid=0. Terminal state.
//  busy = state in {ISSUE,WAIT,VALID}.
//  Throughput with dump_ready tied high: one word every LATENCY+2 cycles.
//  k is 5 bits and never wraps, because the terminal check precedes any increment.
//  run_cnt is 32 bits and saturates at RUN_CYCLES-1; it never wraps.
// STRUCTURE
//  Shared package dlx_pkg:
//   - OPC_ADDI=6'b001000 and INST_NOP=32'h0.
//   - Field positions OPC[31:26], RS[25:21], RT[20:16], IMM[15:0].
//   - State encodings RUN=3'd0, ISSUE=3'd1, WAIT=3'd2, VALID=3'd3, DONE=3'd4.
//  Sub-module: cyc_counter (parameterised width; clear, enable, terminal-count compare).
//   - Instantiated twice: once for run_cnt, once for wait_cnt.
//  All remaining logic is one FSM plus the capture registers.
// TESTING
//  1. Reset, hold halt_req=0, RUN_CYCLES=4, dump_ready=1.
//     override_inst rises exactly 4 cycles after reset release; the first force_inst is 32'h2000_0000.
//  2. busA_probe model returns 32'hA500_0000|rs with 1-cycle lag.
//     Expect 32 words with dump_idx=0..31 and dump_data=A500_0000..A500_001F, in order.
//     done=1 after idx 31, and force_inst=0 afterwards.
//  3. halt_req pulse at cycle 2 with RUN_CYCLES=100: the dump starts at cycle 2.
//     A halt_req asserted on the cycle when run_cnt==RUN_CYCLES-1 produces a single dump, not two.
//  4. Hold dump_ready=0 for 10 cycles with idx=5 valid.
//     dump_valid, dump_idx=5, dump_data and force_inst stay stable; zero words are lost or duplicated.
//  5. Assert reset during WAIT for idx 17: override_inst, dump_valid and busy go 0 immediately.
//     After release the sequence restarts from RUN, and the dump restarts at idx 0.
//  6. LATENCY=3: dump_data equals the busA value sampled 3 cycles after ISSUE, not 1 or 2 cycles after.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: instruction field layout, opcodes used by the
// register dump sequencer, and the sequencer state encoding.
package dlx_pkg;

  localparam logic [5:0]  OPC_ADDI = 6'b001000;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Instruction field positions (I-type layout)
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_t;

  // Build an I-type ADDI rt, rs, imm.
  function automatic logic [31:0] make_addi(input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {OPC_ADDI, rs, rt, imm};
  endfunction

endpackage

// File: rtl/reg_dump_seq_cyc_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Holds at the terminal value, so it can never wrap.
module cyc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_term
);

  logic [WIDTH-1:0] count;

  assign at_term = (count == terminal);

  // Count register: clear wins, otherwise advance until the terminal value.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_seq.sv
// Post-run register dump sequencer. Lets instruction memory drive the core for
// a cycle budget (or until halt_req), then injects ADDI r0,rk,0 for every
// register and streams each busA readout out on a valid/ready interface.
module reg_dump_seq
  import dlx_pkg::*;
#(
  parameter int RUN_CYCLES = 121,
  parameter int NUM_REGS   = 32,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_req,
  input  logic [31:0] busA_probe,
  output logic        override_inst,
  output logic [31:0] force_inst,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done
);

  localparam int         WAIT_W   = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  dump_state_t state, state_next;
  logic [4:0]  k;
  logic        run_at_term;
  logic        wait_at_term;
  logic        accept;

  assign accept = (state == ST_VALID) && dump_ready;

  // run_cnt: counts normal-execution cycles, saturating at RUN_CYCLES-1.
  cyc_counter #(.WIDTH(32)) u_run_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (1'b0),
    .en       (state == ST_RUN),
    .terminal (32'(RUN_CYCLES - 1)),
    .at_term  (run_at_term)
  );

  // wait_cnt: restarted by every ISSUE, measures the core read latency.
  cyc_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (state == ST_ISSUE),
    .en       (state == ST_WAIT),
    .terminal (WAIT_W'(LATENCY - 1)),
    .at_term  (wait_at_term)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Budget expiry and halt_req share one transition.
  // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:   if (run_at_term || halt_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (wait_at_term) state_next = ST_VALID;
      ST_VALID: if (dump_ready) state_next = (k == LAST_IDX) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  // Register index: advances only after a non-final word is accepted, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= '0;
    end else if (accept && (k != LAST_IDX)) begin
      k <= k + 1'b1;
    end
  end

  // Capture registers: sample busA at the end of the wait window, hold through VALID.
  // NOTE: datapath registers are reset too, because they drive outputs that must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_data <= '0;
      dump_idx  <= '0;
    end else if ((state == ST_WAIT) && wait_at_term) begin
      dump_data <= busA_probe;
      dump_idx  <= k;
    end
  end

  // Output decode straight from state, so an async reset drops everything at once.
  always_comb begin
    busy          = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_VALID);
    done          = (state == ST_DONE);
    dump_valid    = (state == ST_VALID);
    override_inst = busy || done;
    force_inst    = busy ? make_addi(k, 5'd0, 16'd0) : INST_NOP;
  end

endmodule

// File: tb/tb_reg_dump_seq.sv
// Self-checking bench for reg_dump_seq: a table of dump scenarios run against
// two configurations (LATENCY=1 and LATENCY=3), with a scoreboard of expected
// register words and hand-coded stall, halt and mid-dump reset sequences.
module tb_reg_dump_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic halt_req;
  logic dump_ready;

  // Configuration A: RUN_CYCLES=4, LATENCY=1
  logic [31:0] busa_a = '0;
  logic        ovr_a, dv_a, busy_a, done_a;
  logic [31:0] fi_a, dd_a;
  logic [4:0]  idx_a;

  // Configuration B: RUN_CYCLES=100, LATENCY=3
  logic [31:0] busa_b = '0;
  logic [31:0] pb1 = '0;
  logic [31:0] pb2 = '0;
  logic        ovr_b, dv_b, busy_b, done_b;
  logic [31:0] fi_b, dd_b;
  logic [4:0]  idx_b;

  reg_dump_seq #(.RUN_CYCLES(4), .NUM_REGS(32), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .halt_req(halt_req), .busA_probe(busa_a),
    .override_inst(ovr_a), .force_inst(fi_a), .dump_valid(dv_a),
    .dump_ready(dump_ready), .dump_idx(idx_a), .dump_data(dd_a),
    .busy(busy_a), .done(done_a)
  );

  reg_dump_seq #(.RUN_CYCLES(100), .NUM_REGS(32), .LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .halt_req(halt_req), .busA_probe(busa_b),
    .override_inst(ovr_b), .force_inst(fi_b), .dump_valid(dv_b),
    .dump_ready(dump_ready), .dump_idx(idx_b), .dump_data(dd_b),
    .busy(busy_b), .done(done_b)
  );

  // Core register-file model: busA returns A500_0000|rs with a fixed lag.
  always @(posedge clk) busa_a <= 32'hA500_0000 | {27'b0, fi_a[25:21]};
  always @(posedge clk) begin
    pb1    <= 32'hA500_0000 | {27'b0, fi_b[25:21]};
    pb2    <= pb1;
    busa_b <= pb2;
  end

  // Selected configuration view
  logic        sel;
  logic        c_ovr, c_dv, c_busy, c_done;
  logic [31:0] c_fi, c_dd;
  logic [4:0]  c_idx;
  assign c_ovr  = sel ? ovr_b  : ovr_a;
  assign c_dv   = sel ? dv_b   : dv_a;
  assign c_busy = sel ? busy_b : busy_a;
  assign c_done = sel ? done_b : done_a;
  assign c_fi   = sel ? fi_b   : fi_a;
  assign c_dd   = sel ? dd_b   : dd_a;
  assign c_idx  = sel ? idx_b  : idx_a;

  typedef struct packed {
    bit use_b;
    int halt_at;    // posedge index at which halt_req is sampled, 0 = none
    int stall_idx;
    int stall_len;  // 0 = no stall
    int abort_idx;  // 0 = no mid-dump reset
    int exp_start;  // negedge count after release at which override_inst is first 1
    int lat;
  } scn_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  word_t q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic check(input string name, input int si,
                       input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (scenario %0d): got %0h, expected %0h", name, si, act, exp);
  endtask

  task automatic run_scn(input int si, input scn_t s);
    int    n;
    int    last_hs;
    int    left;
    int    abort_n;
    bit    started;
    bit    stall_started;
    bit    aborted;
    logic [63:0] snap;
    word_t w;

    sel        = s.use_b;
    halt_req   = 1'b0;
    dump_ready = 1'b1;
    reset      = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    check("reset_ctrl",  si, {c_ovr, c_dv, c_idx, c_busy, c_done}, 64'd0);
    check("reset_force", si, c_fi, 64'd0);
    check("reset_data",  si, c_dd, 64'd0);

    for (int i = 0; i < 32; i++) begin
      w.idx  = 5'(i);
      w.data = 32'hA500_0000 + 32'(i);
      q.push_back(w);
    end

    reset   = 1'b1;
    n       = 0;
    started = 1'b0;
    while (!started && n < 300) begin
      halt_req = (s.halt_at > 0 && n == s.halt_at - 1);
      @(negedge clk);
      n++;
      if (c_ovr) started = 1'b1;
    end
    halt_req = 1'b0;
    if (!started) begin
      check("start_timeout", si, 64'd0, 64'd1);
      return;
    end
    check("start_cycle", si, n, s.exp_start);
    check("first_force", si, c_fi, 64'h2000_0000);
    check("start_busy",  si, {c_busy, c_dv}, 64'b10);

    last_hs       = -1;
    left          = 0;
    abort_n       = -1;
    stall_started = 1'b0;
    aborted       = 1'b0;
    while (q.size() > 0 && n < s.exp_start + 2000) begin
      if (n == abort_n) begin
        check("pre_abort_rs",    si, c_fi[25:21], s.abort_idx);
        check("pre_abort_state", si, {c_ovr, c_dv, c_busy}, 64'b101);
        reset = 1'b0;
        #1;
        check("abort_ctrl_low", si, {c_ovr, c_dv, c_busy}, 64'd0);
        q.delete();
        aborted = 1'b1;
        break;
      end
      if (c_dv) begin
        if (s.stall_len > 0 && c_idx == 5'(s.stall_idx) && !stall_started) begin
          stall_started = 1'b1;
          left          = s.stall_len;
          snap          = {c_fi, c_dd};
        end
        if (left > 0) begin
          if (left != s.stall_len) begin
            check("stall_stable", si, {c_fi, c_dd}, snap);
            check("stall_idx",    si, c_idx, s.stall_idx);
          end
          left--;
          dump_ready = 1'b0;
        end else begin
          dump_ready = 1'b1;
          w = q.pop_front();
          check("dump_idx",  si, c_idx, w.idx);
          check("dump_data", si, c_dd,  w.data);
          if (last_hs >= 0 && !(s.stall_len > 0 && c_idx == 5'(s.stall_idx)))
            check("word_gap", si, n - last_hs, s.lat + 2);
          last_hs = n;
          if (s.abort_idx > 0 && c_idx == 5'(s.abort_idx - 1)) abort_n = n + 2;
        end
      end else begin
        if (left > 0) check("stall_valid_held", si, 64'd0, 64'd1);
        dump_ready = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    dump_ready = 1'b1;
    if (aborted) return;
    if (q.size() > 0) begin
      check("dump_timeout", si, q.size(), 64'd0);
      return;
    end

    @(negedge clk);
    check("done_ctrl", si, {c_done, c_busy, c_ovr, c_dv}, 64'b1010);
    check("done_nop",  si, c_fi, 64'd0);
    repeat (8) @(negedge clk);
    check("done_sticky", si, {c_done, c_busy, c_ovr, c_dv, c_fi}, {32'd0, 4'b1010, 32'd0});
  endtask

  scn_t scns[7];

  initial begin
    reset      = 1'b0;
    halt_req   = 1'b0;
    dump_ready = 1'b1;
    sel        = 1'b0;

    scns[0] = '{use_b:1'b0, halt_at:0, stall_idx:0, stall_len:0,  abort_idx:0,  exp_start:4,   lat:1};
    scns[1] = '{use_b:1'b0, halt_at:4, stall_idx:0, stall_len:0,  abort_idx:0,  exp_start:4,   lat:1};
    scns[2] = '{use_b:1'b0, halt_at:0, stall_idx:5, stall_len:10, abort_idx:0,  exp_start:4,   lat:1};
    scns[3] = '{use_b:1'b0, halt_at:0, stall_idx:0, stall_len:0,  abort_idx:17, exp_start:4,   lat:1};
    scns[4] = '{use_b:1'b0, halt_at:0, stall_idx:0, stall_len:0,  abort_idx:0,  exp_start:4,   lat:1};
    scns[5] = '{use_b:1'b1, halt_at:2, stall_idx:0, stall_len:0,  abort_idx:0,  exp_start:2,   lat:3};
    scns[6] = '{use_b:1'b1, halt_at:0, stall_idx:9, stall_len:4,  abort_idx:0,  exp_start:100, lat:3};

    for (int i = 0; i < 7; i++) run_scn(i, scns[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
